// File: rtl/sipo_rx_if.sv
// Serial-in bus and deserialized-word handshake between a bit source and sipo_rx.
interface sipo_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in;
  logic             enable;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             done;
  logic             busy;
  logic             overrun;

  modport master (
    output in, enable, flush, out_ready,
    input  data_out, data_valid, done, busy, overrun
  );

  modport slave (
    input  in, enable, flush, out_ready,
    output data_out, data_valid, done, busy, overrun
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: MSB-first shift register with a one-entry
// output buffer, valid/ready handoff, abort on flush and sticky overrun.
module sipo_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  sipo_rx_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             word_done;
  logic             buf_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      count_d = '0;
      shift_d = '0;
    end else if (bus.enable) begin
      shift_d = {shift_q[WIDTH-2:0], bus.in};
      if (count_q == LAST) begin
        count_d   = '0;
        state_d   = IDLE;
        word_done = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
        state_d = RECV;
      end
    end
  end

  // A consume in the same cycle frees the buffer, so back-to-back words load without a bubble.
  always_comb begin
    buf_free  = !valid_q || bus.out_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    done_d    = word_done;
    if (word_done && buf_free) begin
      data_d  = shift_d;
      valid_d = 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
    if (bus.flush) begin
      overrun_d = 1'b0;
    end else if (word_done && !buf_free) begin
      overrun_d = 1'b1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q == RECV);
  assign bus.overrun    = overrun_q;
endmodule
